// File: rtl/cpu_defs.sv
// Shared CPU-side definitions: SRAM transfer size codes, requester IDs and the
// lock states used by the memory-port arbiter.
package cpu_defs;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } req_id_e;

  // A stalled address phase pins the grant to one requester until it completes or withdraws.
  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

  function automatic lock_e lock_of(req_id_e id);
    return (id == ID_DATA) ? LK_DATA : LK_INST;
  endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// In-order record of which requester owns each in-flight transaction.
// Push and pop may coincide even when full; the slot being read is freed as the new ID lands.
module resp_id_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    i_push,
  input  req_id_e i_push_id,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output req_id_e o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = req_id_e'(r_mem[r_rd_ptr]);

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between inst fetch (I) and data (D) requesters, data first,
// and steers in-order responses back to whichever side issued each transaction.
module sram_port_arbiter
  import cpu_defs::*;
#(
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // inst port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  // downstream port
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  lock_e   r_lock;
  lock_e   w_lock_nxt;
  req_id_e w_gnt_id;
  req_id_e w_head_id;
  logic    w_gnt_req;
  logic    w_full;
  logic    w_empty;
  logic    w_full_block;
  logic    w_hs;
  logic    w_rsp;

  // Lock state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lock <= LK_NONE;
    else         r_lock <= w_lock_nxt;
  end

  // Grant selection and lock next-state
  always_comb begin
    w_lock_nxt = r_lock;
    w_gnt_id   = d_req ? ID_DATA : ID_INST;
    case (r_lock)
      LK_INST: w_gnt_id = ID_INST;
      LK_DATA: w_gnt_id = ID_DATA;
      default: ;
    endcase
    w_gnt_req = (w_gnt_id == ID_DATA) ? d_req : i_req;

    if (w_hs)                          w_lock_nxt = LK_NONE;
    else if (m_req)                    w_lock_nxt = lock_of(w_gnt_id);
    else if (!w_gnt_req)               w_lock_nxt = LK_NONE;
  end

  // A same-cycle response frees a slot, so full only blocks when nothing is returning.
  assign w_full_block = w_full & ~m_data_ok;
  assign m_req        = w_gnt_req & ~w_full_block & resetn;
  assign w_hs         = m_req & m_addr_ok;

  assign i_addr_ok = w_hs & (w_gnt_id == ID_INST);
  assign d_addr_ok = w_hs & (w_gnt_id == ID_DATA);

  // Inst side is a fixed word read.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = SZ_W;
    m_wstrb = '0;
    m_addr  = i_addr;
    m_wdata = '0;
    if (w_gnt_id == ID_DATA) begin
      m_wr    = d_wr;
      m_size  = d_size;
      m_wstrb = d_wstrb;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  resp_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_hs),
    .i_push_id (w_gnt_id),
    .i_pop     (m_data_ok),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head_id)
  );

  // A response with nothing outstanding is dropped.
  assign w_rsp     = m_data_ok & ~w_empty;
  assign i_data_ok = w_rsp & (w_head_id == ID_INST);
  assign d_data_ok = w_rsp & (w_head_id == ID_DATA);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (MAX_OUT=2): arbitration, lock, full, ordering,
// withdrawal and reset while transactions are in flight.
module tb_sram_port_arbiter;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int n_chk = 0;
  int n_err = 0;

  sram_port_arbiter #(.MAX_OUT(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; i_addr = '0;
    d_req = 0; d_wr = 0; d_size = SZ_W; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  task automatic no_rsp(input string tag);
    chk({tag, "_i_data_ok"}, i_data_ok, 1'b0);
    chk({tag, "_d_data_ok"}, d_data_ok, 1'b0);
  endtask

  initial begin
    idle();
    resetn = 0;
    i_req = 1; m_addr_ok = 1; m_data_ok = 1;
    #2;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_i_addr_ok", i_addr_ok, 1'b0);
    no_rsp("rst");
    cyc(); cyc();
    idle(); resetn = 1;

    // Contention: D wins, I follows next cycle
    cyc();
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_addr = 32'h200; d_wr = 0; d_size = SZ_W;
    m_addr_ok = 1; #1;
    chk("cont_d_addr_ok", d_addr_ok, 1'b1);
    chk("cont_i_addr_ok", i_addr_ok, 1'b0);
    chk("cont_m_addr", m_addr, 32'h200);
    cyc();
    d_req = 0; #1;
    chk("cont2_i_addr_ok", i_addr_ok, 1'b1);
    chk("cont2_m_addr", m_addr, 32'h100);
    chk("cont2_m_size", m_size, SZ_W);
    chk("cont2_m_wstrb", m_wstrb, 4'h0);
    cyc();
    idle(); m_data_ok = 1; m_rdata = 32'h11; #1;
    chk("cont_rsp_d", d_data_ok, 1'b1);
    chk("cont_rsp_i", i_data_ok, 1'b0);
    chk("cont_rsp_d_rdata", d_rdata, 32'h11);
    cyc();
    m_rdata = 32'h22; #1;
    chk("cont_rsp2_i", i_data_ok, 1'b1);
    chk("cont_rsp2_i_rdata", i_rdata, 32'h22);
    cyc();
    m_rdata = 32'h33; #1;
    no_rsp("empty_rsp");
    chk("empty_m_req", m_req, 1'b0);

    // Lock: I stalls, D arrives, grant stays with I until its handshake
    cyc();
    idle(); i_req = 1; i_addr = 32'h300; #1;
    chk("lock1_m_req", m_req, 1'b1);
    chk("lock1_m_addr", m_addr, 32'h300);
    cyc();
    d_req = 1; d_wr = 1; d_addr = 32'h400; d_wdata = 32'hdead; d_wstrb = 4'hf; d_size = SZ_W; #1;
    chk("lock2_m_addr", m_addr, 32'h300);
    chk("lock2_m_wr", m_wr, 1'b0);
    cyc();
    #1;
    chk("lock3_m_addr", m_addr, 32'h300);
    cyc();
    m_addr_ok = 1; #1;
    chk("lock4_i_addr_ok", i_addr_ok, 1'b1);
    chk("lock4_d_addr_ok", d_addr_ok, 1'b0);
    cyc();
    i_req = 0; #1;
    chk("lock5_d_addr_ok", d_addr_ok, 1'b1);
    chk("lock5_m_wr", m_wr, 1'b1);
    chk("lock5_m_wdata", m_wdata, 32'hdead);
    chk("lock5_m_wstrb", m_wstrb, 4'hf);

    // Full: two outstanding (I, D), new I blocked until a response returns
    cyc();
    d_req = 0; d_wr = 0; d_wstrb = '0;
    i_req = 1; i_addr = 32'h500; #1;
    chk("full_m_req", m_req, 1'b0);
    chk("full_i_addr_ok", i_addr_ok, 1'b0);
    cyc();
    m_data_ok = 1; m_rdata = 32'h55; #1;
    chk("full_rsp_i", i_data_ok, 1'b1);
    chk("full_rsp_d", d_data_ok, 1'b0);
    chk("full_m_req2", m_req, 1'b1);
    chk("full_i_addr_ok2", i_addr_ok, 1'b1);
    cyc();
    i_req = 0; m_addr_ok = 0; m_rdata = 32'h66; #1;
    chk("full_drain_d", d_data_ok, 1'b1);
    cyc();
    m_rdata = 32'h77; #1;
    chk("full_drain_i", i_data_ok, 1'b1);
    chk("full_drain_rdata", i_rdata, 32'h77);

    // Ordering: I, D load, I; responses A, B, C
    cyc();
    idle(); i_req = 1; i_addr = 32'h1c000000; m_addr_ok = 1; #1;
    chk("ord1_i_addr_ok", i_addr_ok, 1'b1);
    cyc();
    i_req = 0; d_req = 1; d_addr = 32'h8; d_wr = 0; #1;
    chk("ord2_d_addr_ok", d_addr_ok, 1'b1);
    chk("ord2_m_addr", m_addr, 32'h8);
    cyc();
    d_req = 0; i_req = 1; i_addr = 32'h1c000004;
    m_data_ok = 1; m_rdata = 32'hA; #1;
    chk("ord3_i_addr_ok", i_addr_ok, 1'b1);
    chk("ord3_i_data_ok", i_data_ok, 1'b1);
    chk("ord3_i_rdata", i_rdata, 32'hA);
    cyc();
    i_req = 0; m_rdata = 32'hB; #1;
    chk("ord4_d_data_ok", d_data_ok, 1'b1);
    chk("ord4_i_data_ok", i_data_ok, 1'b0);
    chk("ord4_d_rdata", d_rdata, 32'hB);
    cyc();
    m_rdata = 32'hC; #1;
    chk("ord5_i_data_ok", i_data_ok, 1'b1);
    chk("ord5_d_data_ok", d_data_ok, 1'b0);
    chk("ord5_i_rdata", i_rdata, 32'hC);

    // Withdrawal: D stalls one cycle then drops; I granted only after the lock clears
    cyc();
    idle(); d_req = 1; d_addr = 32'h900; i_req = 1; i_addr = 32'h600; #1;
    chk("wd1_m_addr", m_addr, 32'h900);
    chk("wd1_d_addr_ok", d_addr_ok, 1'b0);
    cyc();
    d_req = 0; m_addr_ok = 1; #1;
    chk("wd2_m_req", m_req, 1'b0);
    chk("wd2_i_addr_ok", i_addr_ok, 1'b0);
    cyc();
    #1;
    chk("wd3_i_addr_ok", i_addr_ok, 1'b1);
    chk("wd3_m_addr", m_addr, 32'h600);
    cyc();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h61; #1;
    chk("wd4_i_data_ok", i_data_ok, 1'b1);
    chk("wd4_d_data_ok", d_data_ok, 1'b0);
    cyc();
    #1;
    no_rsp("wd5");

    // Reset with two in flight
    cyc();
    idle(); i_req = 1; i_addr = 32'h700; m_addr_ok = 1; #1;
    chk("rf1_i_addr_ok", i_addr_ok, 1'b1);
    cyc();
    i_req = 0; d_req = 1; d_addr = 32'h800; #1;
    chk("rf2_d_addr_ok", d_addr_ok, 1'b1);
    cyc();
    #2;
    resetn = 0; i_req = 1; m_data_ok = 1; #1;
    chk("rf_m_req", m_req, 1'b0);
    chk("rf_i_addr_ok", i_addr_ok, 1'b0);
    chk("rf_d_addr_ok", d_addr_ok, 1'b0);
    no_rsp("rf_rst");
    cyc();
    idle(); resetn = 1; m_data_ok = 1; m_rdata = 32'h99; #1;
    no_rsp("rf_post");
    cyc();
    #1;
    no_rsp("rf_post2");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
